pong_game_ctrl: RTL and testbench

Top-level game sequencer for the Pong display. It tracks the game phase, the two-digit BCD score and the balls remaining. It freezes or releases the graphics engine and selects which text regions the overlay may draw: score line, logo, rule box and "Game Over". It sits between the graphics block (hit/miss events), the button inputs and the text overlay, and feeds that overlay its `dig0`, `dig1` and `ball` inputs.

---
 rtl/pong_pkg.sv | 38 +++
 rtl/pong_bcd2_counter.sv | 42 ++++
 rtl/pong_game_ctrl.sv | 123 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game sequencer: state enum,
// text-overlay region bit positions and the per-state region masks.
package pong_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } pong_state_t;

    // Bit positions inside text_mask, ordered {score, logo, rule, over}
    localparam int TEXT_SCORE = 3;
    localparam int TEXT_LOGO  = 2;
    localparam int TEXT_RULE  = 1;
    localparam int TEXT_OVER  = 0;

    function automatic logic [3:0] text_bits(
        input logic score,
        input logic logo,
        input logic rule,
        input logic over
    );
        logic [3:0] m;
        m             = '0;
        m[TEXT_SCORE] = score;
        m[TEXT_LOGO]  = logo;
        m[TEXT_RULE]  = rule;
        m[TEXT_OVER]  = over;
        return m;
    endfunction

    localparam logic [3:0] MASK_NEWGAME = text_bits(1'b1, 1'b1, 1'b1, 1'b0);
    localparam logic [3:0] MASK_PLAY    = text_bits(1'b1, 1'b1, 1'b0, 1'b0);
    localparam logic [3:0] MASK_NEWBALL = text_bits(1'b1, 1'b1, 1'b0, 1'b0);
    localparam logic [3:0] MASK_OVER    = text_bits(1'b1, 1'b1, 1'b0, 1'b1);

endpackage

// File: rtl/pong_bcd2_counter.sv
// Two-digit BCD score counter with synchronous clear and increment.
// PONG_SCORE_SAT_EN: when defined the count sticks at 99, otherwise 99 wraps to 00.
module pong_bcd2_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_dig1,
    output logic [3:0] o_dig0
);

    logic [3:0] r_dig1;
    logic [3:0] r_dig0;
    logic       w_inc_en;

`ifdef PONG_SCORE_SAT_EN
    logic w_at_max;
    assign w_at_max = (r_dig1 == 4'd9) && (r_dig0 == 4'd9);
    assign w_inc_en = i_inc && !w_at_max;
`else
    assign w_inc_en = i_inc;
`endif

    // Clear wins over increment so a score never survives into a new game
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_dig1 <= 4'd0;
            r_dig0 <= 4'd0;
        end else if (w_inc_en) begin
            if (r_dig0 == 4'd9) begin
                r_dig0 <= 4'd0;
                r_dig1 <= (r_dig1 == 4'd9) ? 4'd0 : r_dig1 + 4'd1;
            end else begin
                r_dig0 <= r_dig0 + 4'd1;
            end
        end
    end

    assign o_dig1 = r_dig1;
    assign o_dig0 = r_dig0;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: phase FSM, delay timer, balls remaining and BCD score.
// PONG_SCORE_SAT_EN (see pong_bcd2_counter) selects saturating vs wrapping score.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS       = 3,
    parameter int DELAY_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [3:0] text_mask,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic [1:0] ball
);

    localparam logic [1:0] BALLS_INIT  = 2'(BALLS);
    localparam logic [1:0] BALLS_START = 2'(BALLS - 1);
    localparam logic [6:0] DELAY_INIT  = 7'(DELAY_TICKS);

    pong_state_t r_state;
    logic [6:0]  r_timer;
    logic [1:0]  r_ball;
    logic        r_gra_still;
    logic [3:0]  r_text_mask;

    logic w_btn_pressed;
    logic w_timer_up;
    logic w_timer_load;
    logic w_score_clr;
    logic w_score_inc;

    assign w_btn_pressed = (btn != 2'b00);
    assign w_timer_up    = (r_timer == 7'd0);
    assign w_timer_load  = (r_state == PLAY) && miss;
    assign w_score_inc   = (r_state == PLAY) && hit;
    // Score is cleared on the edge that enters NEWGAME and held at zero there
    assign w_score_clr   = (r_state == NEWGAME) || ((r_state == OVER) && w_timer_up);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 7'd0;
        end else if (w_timer_load) begin
            r_timer <= DELAY_INIT;
        end else if (refr_tick && !w_timer_up) begin
            r_timer <= r_timer - 7'd1;
        end
    end

    // Outputs are registered alongside the state so they change with it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= NEWGAME;
            r_ball      <= BALLS_INIT;
            r_gra_still <= 1'b1;
            r_text_mask <= MASK_NEWGAME;
        end else begin
            case (r_state)
                NEWGAME: begin
                    if (w_btn_pressed) begin
                        r_state     <= PLAY;
                        r_ball      <= BALLS_START;
                        r_gra_still <= 1'b0;
                        r_text_mask <= MASK_PLAY;
                    end
                end
                PLAY: begin
                    if (miss) begin
                        r_gra_still <= 1'b1;
                        if (r_ball == 2'd0) begin
                            r_state     <= OVER;
                            r_text_mask <= MASK_OVER;
                        end else begin
                            r_state     <= NEWBALL;
                            r_ball      <= r_ball - 2'd1;
                            r_text_mask <= MASK_NEWBALL;
                        end
                    end
                end
                NEWBALL: begin
                    if (w_timer_up && w_btn_pressed) begin
                        r_state     <= PLAY;
                        r_gra_still <= 1'b0;
                        r_text_mask <= MASK_PLAY;
                    end
                end
                OVER: begin
                    if (w_timer_up) begin
                        r_state     <= NEWGAME;
                        r_ball      <= BALLS_INIT;
                        r_gra_still <= 1'b1;
                        r_text_mask <= MASK_NEWGAME;
                    end
                end
                default: begin
                    r_state     <= NEWGAME;
                    r_ball      <= BALLS_INIT;
                    r_gra_still <= 1'b1;
                    r_text_mask <= MASK_NEWGAME;
                end
            endcase
        end
    end

    pong_bcd2_counter u_score (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_score_clr),
        .i_inc  (w_score_inc),
        .o_dig1 (dig1),
        .o_dig0 (dig0)
    );

    assign gra_still = r_gra_still;
    assign text_mask = r_text_mask;
    assign ball      = r_ball;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: directed scenarios plus random play,
// checked every cycle against a phase/score/balls reference model.
module tb_pong_game_ctrl;

    localparam int BALLS       = 3;
    localparam int DELAY_TICKS = 4;
`ifdef PONG_SCORE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b00;
    logic       refr_tick = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still;
    logic [3:0] text_mask;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic [1:0] ball;

    pong_game_ctrl #(.BALLS(BALLS), .DELAY_TICKS(DELAY_TICKS)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .refr_tick (refr_tick),
        .hit       (hit),
        .miss      (miss),
        .gra_still (gra_still),
        .text_mask (text_mask),
        .dig1      (dig1),
        .dig0      (dig0),
        .ball      (ball)
    );

    always #5 clk = ~clk;

    // Reference model: game phase name, score as an integer, balls left, frames to wait
    string m_phase = "NEWGAME";
    int    m_score = 0;
    int    m_balls = BALLS;
    int    m_wait  = 0;

    string       tag_q[$];
    logic [14:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          txn    = 0;

    function automatic void model_step(input bit rst, input logic [1:0] b,
                                       input bit t, input bit h, input bit m);
        string ph;
        int    wait_before;
        if (rst) begin
            m_phase = "NEWGAME";
            m_score = 0;
            m_balls = BALLS;
            m_wait  = 0;
            return;
        end
        ph          = m_phase;
        wait_before = m_wait;
        if (ph == "PLAY" && m)
            m_wait = DELAY_TICKS;
        else if (t && m_wait > 0)
            m_wait = m_wait - 1;
        if (ph == "NEWGAME") begin
            m_score = 0;
            if (b != 2'b00) begin
                m_phase = "PLAY";
                m_balls = BALLS - 1;
            end
        end else if (ph == "PLAY") begin
            if (h) m_score = SAT ? ((m_score >= 99) ? 99 : m_score + 1) : (m_score + 1) % 100;
            if (m) begin
                if (m_balls == 0) begin
                    m_phase = "OVER";
                end else begin
                    m_phase = "NEWBALL";
                    m_balls = m_balls - 1;
                end
            end
        end else if (ph == "NEWBALL") begin
            if (wait_before == 0 && b != 2'b00) m_phase = "PLAY";
        end else begin
            if (wait_before == 0) begin
                m_phase = "NEWGAME";
                m_score = 0;
                m_balls = BALLS;
            end
        end
    endfunction

    function automatic logic [14:0] model_out();
        logic       g;
        logic [3:0] mk;
        g = (m_phase != "PLAY");
        if (m_phase == "NEWGAME")   mk = 4'b1110;
        else if (m_phase == "OVER") mk = 4'b1101;
        else                        mk = 4'b1100;
        return {g, mk, 4'(m_score / 10), 4'(m_score % 10), 2'(m_balls)};
    endfunction

    task automatic step(input bit rst, input logic [1:0] b, input bit t,
                        input bit h, input bit m, input string tag);
        @(negedge clk);
        reset     = rst;
        btn       = b;
        refr_tick = t;
        hit       = h;
        miss      = m;
        model_step(rst, b, t, h, m);
        tag_q.push_back(tag);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, tag);
    endtask

    task automatic hits(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 2'b00, 1'($urandom_range(0, 1)), 1'b1, 1'b0, tag);
            if ($urandom_range(0, 3) == 0) idle(1, "play_idle");
        end
    endtask

    // Monitor: every cycle with a pending expectation is one transaction
    always @(posedge clk) begin
        logic [14:0] act;
        logic [14:0] exp_v;
        string       tag;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            act   = {gra_still, text_mask, dig1, dig0, ball};
            checks++;
            txn++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s txn=%0d got still=%b mask=%b dig=%h%h ball=%0d want still=%b mask=%b dig=%h%h ball=%0d",
                         tag, txn, act[14], act[13:10], act[9:6], act[5:2], act[1:0],
                         exp_v[14], exp_v[13:10], exp_v[9:6], exp_v[5:2], exp_v[1:0]);
            end else begin
                $display("txn %0d %s still=%b mask=%b dig=%h%h ball=%0d",
                         txn, tag, act[14], act[13:10], act[9:6], act[5:2], act[1:0]);
            end
        end
    end

    initial begin
        // Reset and start
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "reset");
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, "reset_events");
        idle(2, "reset_idle");
        step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, "start");
        idle(1, "play_idle");

        // Score carry and simultaneous hit+miss
        hits(10, "carry_hit");
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, "hit_miss");

        // NEWBALL gating
        ticks(2, "nb_tick");
        step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, "nb_early_btn");
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "nb_hit_ignored");
        ticks(2, "nb_tick");
        idle(2, "nb_timer_up_no_btn");
        step(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, "nb_btn_play");

        // Last ball, then game over
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "miss_to_nb");
        ticks(4, "nb_tick");
        step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, "nb_btn_play");
        hits(3, "play_hit");
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "miss_to_over");
        step(1'b0, 2'b01, 1'b0, 1'b1, 1'b1, "over_events_ignored");
        ticks(4, "over_tick");
        idle(1, "over_to_newgame");
        idle(1, "newgame_idle");

        // Saturation / wrap at 99
        step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, "start");
        hits(98, "to_98");
        hits(2, "sat_wrap");
        hits(1, "after_99");

        // Reset mid-game in NEWBALL with the timer part-way down
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "miss_to_nb");
        ticks(2, "nb_tick");
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "mid_reset");
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "newgame_hit");
        step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, "restart");
        hits(2, "play_hit");

        // Random play
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] b;
            b = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(($urandom_range(0, 299) == 0), b,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 11) == 0), "random");
        end

        idle(1, "drain");
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
